pixel_out_reader: RTL and testbench

// Read side of the output pixel buffer filled by the GP instruction in the MEM stage.

---
 rtl/pix_pkg.sv | 12 +
 rtl/pixel_out_reader_if.sv | 26 ++
 rtl/pix_skid_fifo.sv | 51 +++++
 rtl/pixel_out_reader.sv | 118 +++++++++++
 tb/tb_pixel_out_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pix_pkg.sv
// Shared constants and types for the output pixel buffer read path.
package pix_pkg;

    localparam int NUM_PIXELS_DEF = 153600;
    localparam int PIX_W_DEF      = 8;
    localparam int ADDR_W_DEF     = 18;

    typedef enum logic [1:0] {RD_IDLE, RD_STREAM, RD_DRAIN} rd_state_t;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

endpackage

// File: rtl/pixel_out_reader_if.sv
// Pixel RAM read port plus valid/ready pixel stream; master is the reader.
interface pixel_out_reader_if
    import pix_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PIX_W  = PIX_W_DEF
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_rdata;
    logic [PIX_W-1:0]  pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_first;
    logic              pix_last;

    modport master (
        output mem_rd_en, mem_addr, pix_data, pix_valid, pix_first, pix_last,
        input  mem_rdata, pix_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr, pix_data, pix_valid, pix_first, pix_last,
        output mem_rdata, pix_ready
    );
endinterface

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO between the RAM read port and the stream; the head only
// moves on pop, so the output holds steady while the sink stalls.
module pix_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign valid = (count != 2'd0);
    assign dout  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/pixel_out_reader.sv
// Frame reader for the output pixel buffer: fetches pixels in order from the
// synchronous RAM, never past the writer's count, and streams them out.
//
// state     | meaning
// RD_IDLE   | waiting for start
// RD_STREAM | issuing reads while rd_addr < NUM_PIXELS
// RD_DRAIN  | all reads issued; emptying FIFO, then done
module pixel_out_reader
    import pix_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [ADDR_W:0] wr_count,
    output logic            busy,
    output logic            done,
    pixel_out_reader_if.master bus
);
    localparam logic [ADDR_W:0] NUM_C  = (ADDR_W+1)'(NUM_PIXELS);
    localparam logic [ADDR_W:0] LAST_C = (ADDR_W+1)'(NUM_PIXELS - 1);

    rd_state_t       state;
    logic [ADDR_W:0] rd_addr;
    logic [ADDR_W:0] out_cnt;
    logic [ADDR_W:0] wr_eff;
    logic            inflight;
    logic [1:0]      fifo_count;
    logic            fifo_valid;
    logic [PIX_W-1:0] fifo_data;
    logic            xfer;
    logic            last_xfer;
    logic            flush;
    logic            issue;
    logic [2:0]      credit_used;

    assign wr_eff    = (wr_count > NUM_C) ? NUM_C : wr_count;
    assign xfer      = fifo_valid && bus.pix_ready;
    assign last_xfer = xfer && (out_cnt == LAST_C);
    assign flush     = (state != RD_IDLE) && abort;

    // A pop in the same cycle frees its slot, which keeps 1 pixel/clk
    // with only two entries of storage.
    assign credit_used = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, xfer};
    assign issue = (state == RD_STREAM) && !abort &&
                   (rd_addr < wr_eff) && (rd_addr < NUM_C) &&
                   (credit_used < 3'd2);

    pix_skid_fifo #(.W(PIX_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .pop   (xfer),
        .flush (flush),
        .din   (bus.mem_rdata),
        .dout  (fifo_data),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RD_IDLE;
            rd_addr  <= '0;
            out_cnt  <= '0;
            inflight <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) rd_addr <= rd_addr + 1'b1;
            if (xfer)  out_cnt <= out_cnt + 1'b1;
            case (state)
                RD_IDLE: begin
                    if (start) begin
                        state   <= RD_STREAM;
                        rd_addr <= '0;
                        out_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                RD_STREAM: begin
                    if (abort) begin
                        state <= RD_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (rd_addr == NUM_C) begin
                        state <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (abort || last_xfer || (fifo_count == 2'd0 && !inflight)) begin
                        state <= RD_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= RD_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_rd_en = issue;
    assign bus.mem_addr  = rd_addr[ADDR_W-1:0];
    assign bus.pix_data  = fifo_data;
    assign bus.pix_valid = fifo_valid;
    assign bus.pix_first = fifo_valid && (out_cnt == '0);
    assign bus.pix_last  = fifo_valid && (out_cnt == LAST_C);

endmodule

// File: tb/tb_pixel_out_reader.sv
// Directed bench for pixel_out_reader with an 8-pixel frame and a scoreboard.
module tb_pixel_out_reader;
    import pix_pkg::*;

    localparam int NP = 8;
    localparam int AW = 4;

    typedef struct packed {
        pixel_t data;
        logic   first;
        logic   last;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW:0]   wr_count;
    logic          busy;
    logic          done;
    pixel_t        ram [16];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   first_cnt = 0;
    int   xfer_cnt = 0;
    int   outstanding = 0;
    logic   prev_stall = 1'b0;
    pixel_t prev_data;
    logic   prev_first;
    logic   prev_last;

    pixel_out_reader_if #(.ADDR_W(AW), .PIX_W(8)) bus ();

    pixel_out_reader #(.NUM_PIXELS(NP), .ADDR_W(AW), .PIX_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .wr_count (wr_count),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_p(input string tag, input pixel_t obs, input pixel_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < NP; i++) begin
            sb.push_back('{data: pixel_t'(8'h10 + i), first: (i == 0), last: (i == NP - 1)});
        end
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n0;
        int i;
        n0 = done_cnt;
        i = 0;
        while (done_cnt == n0 && i < maxc) begin
            tick();
            i++;
        end
        chk_b(tag, done_cnt != n0, 1'b1);
    endtask

    // Stream monitor: scoreboard, hold-while-stalled and outstanding-read checks.
    always @(negedge clk) begin
        logic x;
        if (!rst) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk_b("hold_valid", bus.pix_valid, 1'b1);
                chk_p("hold_data", bus.pix_data, prev_data);
                chk_b("hold_first", bus.pix_first, prev_first);
                chk_b("hold_last", bus.pix_last, prev_last);
            end
            x = bus.pix_valid && bus.pix_ready;
            if (done) done_cnt++;
            if (bus.mem_rd_en)
                chk_b("addr_below_wr_count", ({1'b0, bus.mem_addr} < wr_count), 1'b1);
            if (x) begin
                xfer_cnt++;
                if (bus.pix_first) first_cnt++;
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_underflow observed=%02h expected=none", bus.pix_data);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk_p("sb_data", bus.pix_data, e.data);
                    chk_b("sb_first", bus.pix_first, e.first);
                    chk_b("sb_last", bus.pix_last, e.last);
                end
            end
            if (abort) outstanding = 0;
            else outstanding = outstanding + int'(bus.mem_rd_en) - int'(x);
            if (bus.mem_rd_en) chk_b("outstanding_le2", outstanding <= 2, 1'b1);
            prev_stall = bus.pix_valid && !bus.pix_ready && !abort;
            prev_data  = bus.pix_data;
            prev_first = bus.pix_first;
            prev_last  = bus.pix_last;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int d0;
        int f0;
        int x0;
        int n;
        for (int i = 0; i < 16; i++) ram[i] = pixel_t'(8'h10 + i);
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        wr_count = '0;
        bus.pix_ready = 1'b0;
        tick();
        tick();
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_done", done, 1'b0);
        chk_b("rst_valid", bus.pix_valid, 1'b0);
        chk_b("rst_rd_en", bus.mem_rd_en, 1'b0);
        chk_i("rst_addr", int'(bus.mem_addr), 0);
        chk_p("rst_data", bus.pix_data, 8'h00);
        chk_b("rst_first", bus.pix_first, 1'b0);
        chk_b("rst_last", bus.pix_last, 1'b0);
        rst = 1'b1;
        tick();

        // free run
        wr_count = 5'd8;
        bus.pix_ready = 1'b1;
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_b("fr_busy_early", busy, 1'b1);
        chk_b("fr_rd_en0", bus.mem_rd_en, 1'b1);
        chk_i("fr_addr0", int'(bus.mem_addr), 0);
        chk_b("fr_valid_lat1", bus.pix_valid, 1'b0);
        tick();
        chk_b("fr_valid_lat2", bus.pix_valid, 1'b0);
        chk_i("fr_addr1", int'(bus.mem_addr), 1);
        tick();
        chk_b("fr_valid_lat3", bus.pix_valid, 1'b1);
        chk_p("fr_pix0", bus.pix_data, 8'h10);
        chk_b("fr_first0", bus.pix_first, 1'b1);
        for (int k = 1; k < NP; k++) begin
            tick();
            chk_b("fr_throughput", bus.pix_valid, 1'b1);
            chk_p("fr_pix", bus.pix_data, pixel_t'(8'h10 + k));
            chk_b("fr_first_low", bus.pix_first, 1'b0);
            chk_b("fr_last", bus.pix_last, (k == NP - 1));
            chk_b("fr_busy", busy, 1'b1);
            chk_b("fr_no_done", done, 1'b0);
        end
        tick();
        chk_b("fr_done", done, 1'b1);
        chk_b("fr_busy_off", busy, 1'b0);
        chk_b("fr_valid_off", bus.pix_valid, 1'b0);
        tick();
        chk_b("fr_done_pulse", done, 1'b0);
        chk_i("fr_done_count", done_cnt, 1);
        chk_i("fr_sb_empty", sb.size(), 0);

        // backpressure: ready 1,0,0 repeating
        push_frame();
        d0 = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 80 && done_cnt == d0; i++) begin
            bus.pix_ready = (i % 3 == 0);
            tick();
        end
        bus.pix_ready = 1'b1;
        chk_i("bp_done", done_cnt - d0, 1);
        chk_i("bp_sb_empty", sb.size(), 0);

        // writer stall at 3 pixels
        wr_count = 5'd3;
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        x0 = xfer_cnt;
        repeat (20) tick();
        chk_i("stall_count", xfer_cnt - x0, 3);
        chk_b("stall_valid", bus.pix_valid, 1'b0);
        chk_b("stall_rd_en", bus.mem_rd_en, 1'b0);
        chk_b("stall_busy", busy, 1'b1);
        wr_count = 5'd8;
        wait_done("stall_done", 40);
        chk_i("stall_sb_empty", sb.size(), 0);

        // abort at out_cnt=4, then restart from pixel 0
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        x0 = xfer_cnt;
        n = 0;
        while (xfer_cnt - x0 < 4 && n < 30) begin
            tick();
            n++;
        end
        chk_i("abort_reach4", xfer_cnt - x0, 4);
        chk_p("abort_head", bus.pix_data, 8'h14);
        bus.pix_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_b("abort_valid", bus.pix_valid, 1'b0);
        chk_b("abort_done", done, 1'b1);
        chk_b("abort_busy", busy, 1'b0);
        chk_b("abort_rd_en", bus.mem_rd_en, 1'b0);
        sb.delete();
        bus.pix_ready = 1'b1;
        tick();
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("restart_done", 40);
        chk_i("restart_sb_empty", sb.size(), 0);

        // abort in idle ignored; start with abort in idle wins
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_b("idle_abort_done", done, 1'b0);
        chk_b("idle_abort_busy", busy, 1'b0);
        push_frame();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_b("start_wins_busy", busy, 1'b1);
        wait_done("start_wins_done", 40);
        chk_i("start_wins_sb", sb.size(), 0);

        // wr_count beyond the frame is clamped
        wr_count = 5'd20;
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("clamp_done", 40);
        chk_i("clamp_sb_empty", sb.size(), 0);
        chk_b("clamp_rd_en_idle", bus.mem_rd_en, 1'b0);
        wr_count = 5'd8;

        // asynchronous reset mid-frame
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_b("arst_busy", busy, 1'b0);
        chk_b("arst_done", done, 1'b0);
        chk_b("arst_valid", bus.pix_valid, 1'b0);
        chk_b("arst_rd_en", bus.mem_rd_en, 1'b0);
        chk_i("arst_addr", int'(bus.mem_addr), 0);
        chk_p("arst_data", bus.pix_data, 8'h00);
        chk_b("arst_first", bus.pix_first, 1'b0);
        sb.delete();
        tick();
        rst = 1'b1;
        tick();
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("arst_restart_done", 40);
        chk_i("arst_sb_empty", sb.size(), 0);

        // start while busy is ignored
        d0 = done_cnt;
        f0 = first_cnt;
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_start_done", 40);
        repeat (15) tick();
        chk_i("busy_start_frames", done_cnt - d0, 1);
        chk_i("busy_start_firsts", first_cnt - f0, 1);
        chk_i("busy_start_sb", sb.size(), 0);
        chk_b("busy_start_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
